// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the decoder, plus the execute-unit state encoding
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: combinational ADD/SUB/AND/OR/SLT/XOR evaluator; ports op, a, b in, y out (0 for shift codes)
module alu_comb_core import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = op == ALU_ADD ? a + b :
        op == ALU_SUB ? a - b :
        op == ALU_AND ? a & b :
        op == ALU_OR  ? a | b :
        op == ALU_XOR ? a ^ b :
        op == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} : '0;
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU with valid/ready handshake and bit-serial shifts; ports clk, reset, in_valid/in_ready, alu_control, src_a, src_b, out_valid/out_ready, result, zero, busy
module alu_exec_unit import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  state_t state, next;
  logic [WIDTH-1:0] acc, core_y, shifted, load;
  logic [SHW-1:0] cnt, shamt;
  logic dir, accept, is_shift, last;
  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op(alu_control),
    .a(src_a),
    .b(src_b),
    .y(core_y)
  );
  always_comb begin
    shamt = src_b[SHW-1:0];
    is_shift = alu_control == ALU_SLL || alu_control == ALU_SRL;
    accept = in_valid && in_ready;
    load = is_shift ? src_a : core_y;
    shifted = dir ? acc >> 1 : acc << 1;
    last = cnt == SHW'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state == SHIFT ? (last ? DONE : SHIFT) :
           accept ? (is_shift && |shamt ? SHIFT : DONE) :
           state == DONE && !out_ready ? DONE : IDLE;
  end
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
    busy = state == SHIFT;
  end
  // accept and SHIFT are exclusive because in_ready is low while shifting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      dir <= 1'b0;
      result <= '0;
      zero <= 1'b0;
    end else if (accept) begin
      acc <= src_a;
      cnt <= shamt;
      dir <= alu_control == ALU_SRL;
      if (!(is_shift && |shamt)) begin
        result <= load;
        zero <= ~|load;
      end
    end else if (state == SHIFT) begin
      acc <= shifted;
      cnt <= cnt - 1'b1;
      if (last) begin
        result <= shifted;
        zero <= ~|shifted;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, busy;
  logic [2:0] alu_control = 3'b000;
  logic [31:0] src_a = '0, src_b = '0, result;
  int n_checks = 0, n_fails = 0;
  always #5 clk = ~clk;
  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_control(alu_control),
    .src_a(src_a),
    .src_b(src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_control = op;
    src_a = a;
    src_b = b;
  endtask
  initial begin
    int cyc, seen;
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    req(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    #1;
    check("add_pre_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", result, 32'h8000_0000);
    check("add_zero", 32'(zero), 32'd0);
    tick();
    check("add_drain", 32'(out_valid), 32'd0);
    req(ALU_SUB, 32'd5, 32'd5);
    tick();
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_result", result, 32'd0);
    check("sub_zero", 32'(zero), 32'd1);
    check("sub_in_ready", 32'(in_ready), 32'd1);
    req(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt_valid", 32'(out_valid), 32'd1);
    check("slt_result", result, 32'd1);
    check("slt_zero", 32'(zero), 32'd0);
    req(ALU_SLT, 32'd1, 32'hFFFF_FFFF);
    tick();
    check("slt2_result", result, 32'd0);
    check("slt2_zero", 32'(zero), 32'd1);
    req(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    tick();
    check("and_result", result, 32'h00F0_1234);
    req(ALU_OR, 32'h0000_1200, 32'h0034_0000);
    tick();
    check("or_result", result, 32'h0034_1200);
    in_valid = 1'b0;
    tick();
    check("or_drain", 32'(out_valid), 32'd0);
    req(ALU_SLL, 32'd1, 32'd31);
    tick();
    in_valid = 1'b0;
    check("sll_in_ready", 32'(in_ready), 32'd0);
    check("sll_out_valid", 32'(out_valid), 32'd0);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    check("sll_busy_cycles", 32'(cyc), 32'd31);
    check("sll_valid", 32'(out_valid), 32'd1);
    check("sll_result", result, 32'h8000_0000);
    tick();
    req(ALU_SRL, 32'h8000_0000, 32'd4);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    check("srl_busy_cycles", 32'(cyc), 32'd4);
    check("srl_valid", 32'(out_valid), 32'd1);
    check("srl_result", result, 32'h0800_0000);
    tick();
    req(ALU_SRL, 32'hA5A5_0000, 32'hFFFF_FF00);
    tick();
    in_valid = 1'b0;
    check("srl0_valid", 32'(out_valid), 32'd1);
    check("srl0_busy", 32'(busy), 32'd0);
    check("srl0_result", result, 32'hA5A5_0000);
    tick();
    out_ready = 1'b0;
    req(ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    tick();
    req(ALU_ADD, 32'd2, 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, 32'hF00F_F00F);
      check("bp_zero", 32'(zero), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", result, 32'd5);
    tick();
    req(ALU_SLL, 32'd1, 32'd10);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    check("abort_no_result", 32'(seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
